alu_commit: RTL

ALU_COMMIT -- requirements
Module: alu_commit

---
 rtl/alu_commit_pkg.sv | 50 +++++
 rtl/alu_commit_wait.sv | 30 +++
 rtl/alu_commit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alu_commit_pkg.sv
// Shared defines for the ALU commit path: register width, status bit positions,
// destination and FSM encodings, timeout counter width, status merge helper.
package alu_commit_pkg;

  localparam int REG_WIDTH = 8;
  localparam int TMO_W     = 4;

  localparam int ST_C = 0;
  localparam int ST_Z = 1;
  localparam int ST_I = 2;
  localparam int ST_D = 3;
  localparam int ST_B = 4;
  localparam int ST_U = 5;
  localparam int ST_V = 6;
  localparam int ST_N = 7;

  typedef enum logic [2:0] {
    DEST_A    = 3'd0,
    DEST_X    = 3'd1,
    DEST_Y    = 3'd2,
    DEST_SP   = 3'd3,
    DEST_MEM  = 3'd4,
    DEST_NONE = 3'd5
  } dest_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_ABORT  = 3'd4
  } state_t;

  // Z and N always reflect the data itself; B and bit 5 are never touched by an ALU op.
  function automatic logic [REG_WIDTH-1:0] merge_status(
    input logic [REG_WIDTH-1:0] alu_st,
    input logic [REG_WIDTH-1:0] cur,
    input logic [REG_WIDTH-1:0] mask,
    input logic [REG_WIDTH-1:0] dout
  );
    logic [REG_WIDTH-1:0] r;
    r = (alu_st & mask) | (cur & ~mask);
    if (mask[ST_Z]) r[ST_Z] = (dout == '0);
    if (mask[ST_N]) r[ST_N] = dout[REG_WIDTH-1];
    r[ST_B] = cur[ST_B];
    r[ST_U] = cur[ST_U];
    return r;
  endfunction

endpackage

// File: rtl/alu_commit_wait.sv
// Cycle counter bounding the ARM/WAIT window of alu_commit.
// Latency: expired is combinational from the count; count updates each enabled edge.
// Backpressure: none; saturates at TIMEOUT-1 until cleared.
module alu_wait_timer
  import alu_commit_pkg::*;
#(
  parameter int TIMEOUT = 4
) (
  input  logic phi1,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TMO_W-1:0] count;

  assign expired = (count == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_commit.sv
// Commits one ALU result per start: register/memory write plus merged status.
// Latency: start at edge N, wout low at N+1, high at N+2 -> write strobes after edge N+3.
// Backpressure: start is ignored while busy; no queueing, timeout aborts a stalled ALU.
module alu_commit
  import alu_commit_pkg::*;
#(
  parameter int TIMEOUT = 4
) (
  input  logic                 phi1,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           dest,
  input  logic [REG_WIDTH-1:0] flag_mask,
  input  logic [REG_WIDTH-1:0] alu_dout,
  input  logic [REG_WIDTH-1:0] alu_status,
  input  logic                 alu_wout,
  input  logic [REG_WIDTH-1:0] status_cur,
  output logic [3:0]           reg_we,
  output logic [REG_WIDTH-1:0] reg_dout,
  output logic                 mem_we,
  output logic [REG_WIDTH-1:0] mem_dout,
  output logic                 status_we,
  output logic [REG_WIDTH-1:0] status_dout,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err
);

  state_t               state;
  logic [2:0]           dest_q;
  logic [REG_WIDTH-1:0] mask_q;
  logic [REG_WIDTH-1:0] dout_q;
  logic [REG_WIDTH-1:0] stat_q;
  logic                 tmr_clear;
  logic                 tmr_enable;
  logic                 expired;

  assign tmr_clear  = (state == ST_IDLE);
  assign tmr_enable = (state == ST_ARM) || (state == ST_WAIT);

  alu_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .phi1    (phi1),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (expired)
  );

  always_ff @(posedge phi1 or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      dest_q      <= DEST_NONE;
      mask_q      <= '0;
      dout_q      <= '0;
      stat_q      <= '0;
      reg_we      <= '0;
      reg_dout    <= '0;
      mem_we      <= 1'b0;
      mem_dout    <= '0;
      status_we   <= 1'b0;
      status_dout <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      reg_we    <= '0;
      mem_we    <= 1'b0;
      status_we <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            dest_q      <= dest;
            mask_q      <= flag_mask;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
            state       <= ST_ARM;
          end
        end
        // A result still held valid from the previous op must drop before we trust wout.
        ST_ARM: begin
          if (expired)        state <= ST_ABORT;
          else if (!alu_wout) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (alu_wout) begin
            dout_q <= alu_dout;
            stat_q <= alu_status;
            state  <= ST_COMMIT;
          end else if (expired) begin
            state <= ST_ABORT;
          end
        end
        ST_COMMIT: begin
          done        <= 1'b1;
          status_we   <= 1'b1;
          reg_dout    <= dout_q;
          mem_dout    <= dout_q;
          status_dout <= merge_status(stat_q, status_cur, mask_q, dout_q);
          case (dest_q)
            DEST_A:   reg_we <= 4'b0001;
            DEST_X:   reg_we <= 4'b0010;
            DEST_Y:   reg_we <= 4'b0100;
            DEST_SP:  reg_we <= 4'b1000;
            DEST_MEM: mem_we <= 1'b1;
            default:  ;
          endcase
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_ABORT: begin
          done        <= 1'b1;
          timeout_err <= 1'b1;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
